axi_ram_slave: RTL

- AXI3 slave responder backed by an internal word-addressed RAM. It is the memory-side end of the bus that the CPU-side sram-to-AXI bridge masters.
- Read and write channels run independent FSMs. Single-beat and INCR/FIXED bursts up to 16 beats are supported.
- Used as the simulation/SoC memory target behind the CPU's AXI master.

---
 rtl/axi_ram_slave_if.sv | 66 ++++++
 rtl/axi_ram_slave.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave_if.sv
// AXI3 bus bundle between a CPU-side master and the RAM slave.
// Clock and reset are kept outside the interface as plain ports.
interface axi_ram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI3 slave backed by a word-addressed RAM; independent read and write FSMs,
// INCR/FIXED bursts up to 16 beats, DECERR outside BASE_HI, SLVERR on wlast mismatch.
module axi_ram_slave #(
    parameter int          MEM_AW  = 10,
    parameter logic [31:0] BASE_HI = 32'h0
) (
    input  logic            aclk,
    input  logic            aresetn,
    axi_ram_slave_if.slave  bus,
    output logic            rd_state,
    output logic [1:0]      wr_state
);
    // Every channel transfers on valid & ready at a rising edge; a source holds
    // its payload stable while valid=1 and ready=0.
    localparam int HW = 30 - MEM_AW;
    localparam logic [HW-1:0] BASE = BASE_HI[HW-1:0];

    typedef logic [MEM_AW-1:0] idx_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} w_state_t;

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    // ---------------- read channel ----------------
    r_state_t    r_state, r_next;
    logic        ar_ready_q;
    logic [3:0]  r_id, r_len, r_beat;
    idx_t        r_idx, r_idx_next, ar_idx;
    logic        r_fixed, r_err, ar_ok, ar_hs, r_hs, r_last_beat;
    logic [31:0] r_data;

    assign ar_idx      = bus.araddr[MEM_AW+1:2];
    assign ar_ok       = (bus.araddr[31:MEM_AW+2] == BASE);
    assign ar_hs       = bus.arvalid & ar_ready_q;
    assign r_hs        = (r_state == R_DATA) & bus.rready;
    assign r_last_beat = (r_beat == r_len);
    assign r_idx_next  = r_fixed ? r_idx : r_idx + idx_t'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_ready_q <= 1'b0;
            r_id       <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_idx      <= '0;
            r_fixed    <= 1'b0;
            r_err      <= 1'b0;
            r_data     <= '0;
        end else begin
            ar_ready_q <= (r_next == R_IDLE);
            if (ar_hs) begin
                r_id    <= bus.arid;
                r_len   <= bus.arlen;
                r_beat  <= '0;
                r_idx   <= ar_idx;
                r_fixed <= (bus.arburst == 2'b00);
                r_err   <= !ar_ok;
                r_data  <= ar_ok ? mem[ar_idx] : 32'h0;
            end else if (r_hs && !r_last_beat) begin
                // Next beat is fetched on the accepting edge, so beats stream without bubbles.
                r_idx  <= r_idx_next;
                r_beat <= r_beat + 4'd1;
                r_data <= r_err ? 32'h0 : mem[r_idx_next];
            end
        end
    end

    assign bus.arready = ar_ready_q;
    assign bus.rvalid  = (r_state == R_DATA);
    assign bus.rid     = r_id;
    assign bus.rdata   = r_data;
    assign bus.rresp   = r_err ? 2'b11 : 2'b00;
    assign bus.rlast   = (r_state == R_DATA) & r_last_beat;
    assign rd_state    = r_state;

    // ---------------- write channel ----------------
    w_state_t    w_state, w_next;
    logic        aw_ready_q;
    logic [3:0]  w_id, w_len, w_beat;
    idx_t        w_idx, w_idx_next;
    logic        w_fixed, aw_ok, aw_hs, w_hs, b_hs, w_last_beat;
    logic [1:0]  w_err;

    assign aw_ok       = (bus.awaddr[31:MEM_AW+2] == BASE);
    assign aw_hs       = bus.awvalid & aw_ready_q;
    assign w_hs        = (w_state == W_DATA) & bus.wvalid;
    assign b_hs        = (w_state == W_RESP) & bus.bready;
    assign w_last_beat = (w_beat == w_len);
    assign w_idx_next  = w_fixed ? w_idx : w_idx + idx_t'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_ready_q <= 1'b0;
            w_id       <= '0;
            w_len      <= '0;
            w_beat     <= '0;
            w_idx      <= '0;
            w_fixed    <= 1'b0;
            w_err      <= 2'b00;
        end else begin
            aw_ready_q <= (w_next == W_IDLE);
            if (aw_hs) begin
                w_id    <= bus.awid;
                w_len   <= bus.awlen;
                w_beat  <= '0;
                w_idx   <= bus.awaddr[MEM_AW+1:2];
                w_fixed <= (bus.awburst == 2'b00);
                w_err   <= aw_ok ? 2'b00 : 2'b11;
            end else if (w_hs) begin
                if (!w_last_beat) begin
                    w_idx  <= w_idx_next;
                    w_beat <= w_beat + 4'd1;
                end
                // DECERR from the address phase outranks a late wlast mismatch.
                if ((bus.wlast != w_last_beat) && (w_err != 2'b11))
                    w_err <= 2'b10;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && (w_err != 2'b11)) begin
            for (int i = 0; i < 4; i++)
                if (bus.wstrb[i]) mem[w_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
    end

    assign bus.awready = aw_ready_q;
    assign bus.wready  = (w_state == W_DATA);
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bid     = w_id;
    assign bus.bresp   = w_err;
    assign wr_state    = w_state;

    logic unused_fields;
    assign unused_fields = ^{bus.arsize, bus.arlock, bus.arcache, bus.arprot, bus.araddr[1:0],
                             bus.awsize, bus.awlock, bus.awcache, bus.awprot, bus.awaddr[1:0],
                             bus.wid};
endmodule
